can_tx_scheduler: RTL and testbench

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

---
 rtl/can_tx_scheduler_pkg.sv | 19 +
 rtl/can_tx_scheduler_prio.sv | 36 +++
 rtl/can_tx_scheduler.sv | 169 ++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_tx_scheduler_pkg.sv
// Shared definitions for the CAN transmit scheduler.
//   state_t     : scheduler FSM states (IDLE, SELECT, LAUNCH, WAIT)
//   CAN_ID_W    : standard CAN identifier width (11)
//   CAN_DATA_W  : payload width, up to 8 bytes (64)
//   RETRY_W     : width of the per-mailbox tx_error counter
package can_tx_scheduler_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DATA_W = 64;
    localparam int RETRY_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_LAUNCH = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

endpackage

// File: rtl/can_tx_scheduler_prio.sv
// can_prio_select: combinational CAN-priority picker.
//   pending : one bit per mailbox, set when the mailbox competes
//   ids     : identifier of each mailbox
//   win_idx : index of the pending mailbox with the lowest identifier
//   win_vld : at least one mailbox is pending
// Ties go to the lowest mailbox index because the scan runs upward and
// only replaces the current best on a strictly lower identifier.
module can_prio_select
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]                pending,
    input  logic [NUM_MB-1:0][CAN_ID_W-1:0]  ids,
    output logic [$clog2(NUM_MB)-1:0]        win_idx,
    output logic                             win_vld
);

    localparam int IDX_W = $clog2(NUM_MB);

    logic [CAN_ID_W-1:0] best_id;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        best_id = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pending[i] && (!win_vld || (ids[i] < best_id))) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
                best_id = ids[i];
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: picks the highest-priority (lowest-ID) pending mailbox,
// launches it to the CAN transmitter and handles the transfer outcome.
//   clk, reset                : system clock, synchronous active-high reset
//   mb_load/mb_id/mb_data     : per-mailbox write strobe plus shared id/payload
//   mb_abort                  : per-mailbox cancel strobe
//   mb_pending/mb_done/mb_fail: mailbox status level and one-cycle pulses
//   tx_send/tx_id/tx_data     : launch pulse and active frame to transmitter
//   tx_done/tx_arb_lost/tx_error : outcome pulses from the transmitter
module can_tx_scheduler
    import can_tx_scheduler_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int RETRY_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_MB-1:0]      mb_load,
    input  logic [CAN_ID_W-1:0]    mb_id,
    input  logic [CAN_DATA_W-1:0]  mb_data,
    input  logic [NUM_MB-1:0]      mb_abort,
    output logic [NUM_MB-1:0]      mb_pending,
    output logic [NUM_MB-1:0]      mb_done,
    output logic [NUM_MB-1:0]      mb_fail,
    output logic                   tx_send,
    output logic [CAN_ID_W-1:0]    tx_id,
    output logic [CAN_DATA_W-1:0]  tx_data,
    input  logic                   tx_done,
    input  logic                   tx_arb_lost,
    input  logic                   tx_error
);

    localparam int IDX_W = $clog2(NUM_MB);

    state_t                              state;
    logic [IDX_W-1:0]                    act_idx;
    logic [IDX_W-1:0]                    cur_act;
    logic                                act_vld;
    logic [IDX_W-1:0]                    win_idx;
    logic                                win_vld;
    logic [NUM_MB-1:0][CAN_ID_W-1:0]     id_q;
    logic [CAN_DATA_W-1:0]               data_q [NUM_MB];
    logic [RETRY_W-1:0]                  retry_cnt [NUM_MB];
    logic [RETRY_W-1:0]                  retry_nxt;
    logic [NUM_MB-1:0]                   abort_lat;
    logic [NUM_MB-1:0]                   is_act;
    logic [NUM_MB-1:0]                   load_acc;
    logic                                outcome;

    can_prio_select #(.NUM_MB(NUM_MB)) u_prio (
        .pending (mb_pending),
        .ids     (id_q),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // During SELECT the mailbox about to win is already treated as active,
    // so a load cannot change the frame between selection and launch.
    always_comb begin
        cur_act  = (state == ST_SELECT) ? win_idx : act_idx;
        act_vld  = (state == ST_SELECT) ? win_vld
                                        : ((state == ST_LAUNCH) || (state == ST_WAIT));
        is_act   = '0;
        load_acc = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            is_act[i]   = act_vld && (cur_act == IDX_W'(i));
            load_acc[i] = mb_load[i] && !mb_abort[i] && !is_act[i];
        end
        retry_nxt = retry_cnt[act_idx] + RETRY_W'(1);
        outcome   = (state == ST_WAIT) && (tx_done || tx_error || tx_arb_lost);
    end

    // Frame storage carries no reset; pending qualifies its contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_MB; i++) begin
            if (load_acc[i]) begin
                id_q[i]   <= mb_id;
                data_q[i] <= mb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            act_idx    <= '0;
            mb_pending <= '0;
            mb_done    <= '0;
            mb_fail    <= '0;
            tx_send    <= 1'b0;
            tx_id      <= '0;
            tx_data    <= '0;
            abort_lat  <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                retry_cnt[i] <= '0;
            end
        end else begin
            mb_done <= '0;
            mb_fail <= '0;
            tx_send <= 1'b0;

            // Host side: loads and aborts; an abort of the active mailbox
            // is deferred until the transmitter reports the outcome.
            for (int i = 0; i < NUM_MB; i++) begin
                if (is_act[i]) begin
                    if (mb_abort[i]) begin
                        abort_lat[i] <= 1'b1;
                    end
                end else if (mb_abort[i]) begin
                    if (mb_pending[i]) begin
                        mb_pending[i] <= 1'b0;
                        mb_fail[i]    <= 1'b1;
                    end
                end else if (load_acc[i]) begin
                    mb_pending[i] <= 1'b1;
                    retry_cnt[i]  <= '0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|mb_pending) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    // Everything may have been aborted in the meantime.
                    if (win_vld) begin
                        act_idx <= win_idx;
                        tx_id   <= id_q[win_idx];
                        tx_data <= data_q[win_idx];
                        tx_send <= 1'b1;
                        state   <= ST_LAUNCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (outcome) begin
                        state              <= ST_IDLE;
                        abort_lat[act_idx] <= 1'b0;
                        if (tx_done) begin
                            mb_pending[act_idx] <= 1'b0;
                            mb_done[act_idx]    <= 1'b1;
                            retry_cnt[act_idx]  <= '0;
                        end else if (abort_lat[act_idx] || mb_abort[act_idx]) begin
                            mb_pending[act_idx] <= 1'b0;
                            mb_fail[act_idx]    <= 1'b1;
                            retry_cnt[act_idx]  <= '0;
                        end else if (tx_error) begin
                            if (retry_nxt == RETRY_W'(RETRY_MAX)) begin
                                mb_pending[act_idx] <= 1'b0;
                                mb_fail[act_idx]    <= 1'b1;
                                retry_cnt[act_idx]  <= '0;
                            end else begin
                                retry_cnt[act_idx] <= retry_nxt;
                            end
                        end
                        // tx_arb_lost alone: stay pending, retry count untouched.
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler (NUM_MB=4, RETRY_MAX=3).
module tb_can_tx_scheduler;
    import can_tx_scheduler_pkg::*;

    localparam int NUM_MB    = 4;
    localparam int RETRY_MAX = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_MB-1:0]     mb_load;
    logic [CAN_ID_W-1:0]   mb_id;
    logic [CAN_DATA_W-1:0] mb_data;
    logic [NUM_MB-1:0]     mb_abort;
    logic [NUM_MB-1:0]     mb_pending;
    logic [NUM_MB-1:0]     mb_done;
    logic [NUM_MB-1:0]     mb_fail;
    logic                  tx_send;
    logic [CAN_ID_W-1:0]   tx_id;
    logic [CAN_DATA_W-1:0] tx_data;
    logic                  tx_done;
    logic                  tx_arb_lost;
    logic                  tx_error;

    always #5 clk = ~clk;

    can_tx_scheduler #(.NUM_MB(NUM_MB), .RETRY_MAX(RETRY_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .mb_load     (mb_load),
        .mb_id       (mb_id),
        .mb_data     (mb_data),
        .mb_abort    (mb_abort),
        .mb_pending  (mb_pending),
        .mb_done     (mb_done),
        .mb_fail     (mb_fail),
        .tx_send     (tx_send),
        .tx_id       (tx_id),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .tx_arb_lost (tx_arb_lost),
        .tx_error    (tx_error)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][10:0] ids;   // {mb3, mb2, mb1, mb0}
        logic [3:0]       mask;
        logic [1:0]       exp;
    } pvec_t;

    pvec_t tbl [5];

    // reference model state
    logic [10:0] m_id   [NUM_MB];
    logic [63:0] m_data [NUM_MB];
    bit          m_pend [NUM_MB];
    int          m_retry[NUM_MB];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        mb_load     = '0;
        mb_abort    = '0;
        tx_done     = 1'b0;
        tx_arb_lost = 1'b0;
        tx_error    = 1'b0;
    endtask

    task automatic do_reset;
        clear_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic load_mb(input logic [3:0] m, input logic [10:0] id, input logic [63:0] d);
        mb_load = m;
        mb_id   = id;
        mb_data = d;
        tick();
        mb_load = '0;
    endtask

    // kind: 0 = tx_done, 1 = tx_error, 2 = tx_arb_lost
    task automatic outcome(input int kind);
        tx_done     = (kind == 0);
        tx_error    = (kind == 1);
        tx_arb_lost = (kind == 2);
        tick();
        clear_in();
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (tx_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got no tx_send, required one within 20 cycles");
        end
    endtask

    task automatic count_sends(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (tx_send === 1'b1) c++;
        end
    endtask

    function automatic logic [63:0] mkdata(input int i, input logic [10:0] id);
        return {32'hC0DE0000 + 32'(i), 21'h0, id};
    endfunction

    function automatic int model_best();
        int b = -1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (m_pend[i] && (b < 0 || m_id[i] < m_id[b])) b = i;
        end
        return b;
    endfunction

    function automatic logic [3:0] model_pvec();
        logic [3:0] v = '0;
        for (int i = 0; i < NUM_MB; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [10:0] rnd_id();
        if ($urandom_range(0, 3) == 0) return 11'h100;
        return 11'($urandom_range(0, 2047));
    endfunction

    initial begin
        bit ok;
        int c, launches, f, exp_i, j, k;
        logic [3:0] ed, ef;

        tbl[0] = '{ids: {11'h200, 11'h7FF, 11'h045, 11'h123}, mask: 4'b1111, exp: 2'd1};
        tbl[1] = '{ids: {11'h100, 11'h100, 11'h100, 11'h100}, mask: 4'b1010, exp: 2'd1};
        tbl[2] = '{ids: {11'h7FF, 11'h000, 11'h001, 11'h000}, mask: 4'b1111, exp: 2'd0};
        tbl[3] = '{ids: {11'h7FE, 11'h7FF, 11'h7FE, 11'h7FF}, mask: 4'b1101, exp: 2'd3};
        tbl[4] = '{ids: {11'h001, 11'h301, 11'h2FF, 11'h300}, mask: 4'b0111, exp: 2'd1};

        mb_id   = '0;
        mb_data = '0;

        // reset state
        do_reset();
        reset = 1'b1;
        tick();
        chk("rst_pending", 64'(mb_pending), 64'h0);
        chk("rst_done",    64'(mb_done),    64'h0);
        chk("rst_fail",    64'(mb_fail),    64'h0);
        chk("rst_send",    64'(tx_send),    64'h0);
        chk("rst_tx_id",   64'(tx_id),      64'h0);
        chk("rst_tx_data", tx_data,         64'h0);
        reset = 1'b0;

        // two loads, lower id wins; 2-cycle launch latency; tx_done ordering
        do_reset();
        load_mb(4'b0001, 11'h123, mkdata(0, 11'h123));
        chk("lat_send_c1", 64'(tx_send), 64'h0);
        load_mb(4'b0100, 11'h045, mkdata(2, 11'h045));
        chk("lat_send_c2", 64'(tx_send), 64'h0);
        tick();
        chk("lat_send_c3", 64'(tx_send), 64'h1);
        chk("first_id",    64'(tx_id), 64'h045);
        chk("first_data",  tx_data, mkdata(2, 11'h045));
        tick();
        chk("send_pulse",  64'(tx_send), 64'h0);
        chk("tx_id_hold",  64'(tx_id), 64'h045);
        outcome(0);
        chk("done_mb2",    64'(mb_done), 64'h4);
        chk("pend_after",  64'(mb_pending), 64'h1);
        tick();
        chk("done_pulse",  64'(mb_done), 64'h0);
        wait_send(ok);
        chk("second_id",   64'(tx_id), 64'h123);
        tick();
        outcome(0);
        chk("done_mb0",    64'(mb_done), 64'h1);

        // priority table
        for (int t = 0; t < 5; t++) begin
            do_reset();
            f = 0;
            for (int i = NUM_MB - 1; i >= 0; i--) if (tbl[t].mask[i]) f = i;
            load_mb(4'(1 << f), tbl[t].ids[f], mkdata(f, tbl[t].ids[f]));
            wait_send(ok);
            chk($sformatf("tbl%0d_first", t), 64'(tx_id), 64'(tbl[t].ids[f]));
            tick();
            for (int i = 0; i < NUM_MB; i++) begin
                if (tbl[t].mask[i] && i != f) load_mb(4'(1 << i), tbl[t].ids[i], mkdata(i, tbl[t].ids[i]));
            end
            outcome(2);
            chk($sformatf("tbl%0d_pend", t), 64'(mb_pending), 64'(tbl[t].mask));
            wait_send(ok);
            chk($sformatf("tbl%0d_id", t), 64'(tx_id), 64'(tbl[t].ids[tbl[t].exp]));
            chk($sformatf("tbl%0d_data", t), tx_data, mkdata(int'(tbl[t].exp), tbl[t].ids[tbl[t].exp]));
        end

        // retries exhausted after RETRY_MAX tx_error outcomes
        do_reset();
        load_mb(4'b0001, 11'h222, mkdata(0, 11'h222));
        launches = 0;
        for (int n = 0; n < RETRY_MAX; n++) begin
            wait_send(ok);
            if (ok) launches++;
            tick();
            outcome(1);
            if (n < RETRY_MAX - 1) begin
                chk("retry_nofail", 64'(mb_fail), 64'h0);
                chk("retry_pend",   64'(mb_pending), 64'h1);
            end else begin
                chk("retry_fail",     64'(mb_fail), 64'h1);
                chk("retry_pend_end", 64'(mb_pending), 64'h0);
            end
        end
        count_sends(10, c);
        chk("retry_launches", 64'(launches + c), 64'd3);

        // arbitration loss does not consume retries
        do_reset();
        load_mb(4'b0001, 11'h333, mkdata(0, 11'h333));
        launches = 0;
        for (int n = 0; n < 6; n++) begin
            wait_send(ok);
            if (ok) launches++;
            tick();
            outcome(n < 5 ? 2 : 0);
            chk("arb_nofail", 64'(mb_fail), 64'h0);
        end
        chk("arb_done", 64'(mb_done), 64'h1);
        chk("arb_launches", 64'(launches), 64'd6);

        // abort of active (deferred) and non-active (immediate) mailboxes
        do_reset();
        load_mb(4'b0010, 11'h050, mkdata(1, 11'h050));
        load_mb(4'b0100, 11'h060, mkdata(2, 11'h060));
        wait_send(ok);
        chk("abt_active_id", 64'(tx_id), 64'h050);
        tick();
        mb_abort = 4'b0010;
        tick();
        mb_abort = '0;
        chk("abt_latched_nofail", 64'(mb_fail), 64'h0);
        chk("abt_latched_pend",   64'(mb_pending), 64'h6);
        mb_abort = 4'b0100;
        tick();
        mb_abort = '0;
        chk("abt_mb2_fail", 64'(mb_fail), 64'h4);
        chk("abt_mb2_pend", 64'(mb_pending), 64'h2);
        outcome(1);
        chk("abt_mb1_fail", 64'(mb_fail), 64'h2);
        chk("abt_mb1_pend", 64'(mb_pending), 64'h0);
        count_sends(8, c);
        chk("abt_no_relaunch", 64'(c), 64'd0);

        // reset in WAIT with three mailboxes pending
        do_reset();
        load_mb(4'b0111, 11'h010, mkdata(7, 11'h010));
        wait_send(ok);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_pend", 64'(mb_pending), 64'h0);
        chk("mid_rst_done", 64'(mb_done), 64'h0);
        chk("mid_rst_fail", 64'(mb_fail), 64'h0);
        chk("mid_rst_send", 64'(tx_send), 64'h0);
        chk("mid_rst_id",   64'(tx_id), 64'h0);
        chk("mid_rst_data", tx_data, 64'h0);
        tx_done = 1'b1;
        tick();
        clear_in();
        chk("late_done_ignored", 64'(mb_done), 64'h0);
        count_sends(8, c);
        chk("mid_rst_no_send", 64'(c), 64'd0);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < NUM_MB; i++) begin
            m_pend[i] = 0; m_retry[i] = 0; m_id[i] = '0; m_data[i] = '0;
        end
        for (int r = 0; r < 30; r++) begin
            j = $urandom_range(0, NUM_MB - 1);
            m_id[j] = rnd_id(); m_data[j] = {$urandom, $urandom};
            m_pend[j] = 1; m_retry[j] = 0;
            load_mb(4'(1 << j), m_id[j], m_data[j]);
            for (int g = 0; g < 100 && model_best() >= 0; g++) begin
                exp_i = model_best();
                wait_send(ok);
                if (!ok) break;
                chk("rnd_id",   64'(tx_id), 64'(m_id[exp_i]));
                chk("rnd_data", tx_data, m_data[exp_i]);
                tick();
                if ($urandom_range(0, 2) == 0) begin
                    j = $urandom_range(0, NUM_MB - 1);
                    if (j != exp_i) begin
                        m_id[j] = rnd_id(); m_data[j] = {$urandom, $urandom};
                        m_pend[j] = 1; m_retry[j] = 0;
                        load_mb(4'(1 << j), m_id[j], m_data[j]);
                        chk("rnd_load_pend", 64'(mb_pending), 64'(model_pvec()));
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    j = $urandom_range(0, NUM_MB - 1);
                    if (j != exp_i) begin
                        ef = m_pend[j] ? 4'(1 << j) : 4'h0;
                        m_pend[j] = 0; m_retry[j] = 0;
                        mb_abort = 4'(1 << j);
                        tick();
                        mb_abort = '0;
                        chk("rnd_abort_fail", 64'(mb_fail), 64'(ef));
                        chk("rnd_abort_pend", 64'(mb_pending), 64'(model_pvec()));
                    end
                end
                k = $urandom_range(0, 9);
                k = (k < 4) ? 0 : (k < 7) ? 1 : 2;
                ed = '0; ef = '0;
                if (k == 0) begin
                    m_pend[exp_i] = 0; m_retry[exp_i] = 0; ed = 4'(1 << exp_i);
                end else if (k == 1) begin
                    m_retry[exp_i]++;
                    if (m_retry[exp_i] == RETRY_MAX) begin
                        m_pend[exp_i] = 0; m_retry[exp_i] = 0; ef = 4'(1 << exp_i);
                    end
                end
                outcome(k);
                chk("rnd_done", 64'(mb_done), 64'(ed));
                chk("rnd_fail", 64'(mb_fail), 64'(ef));
                chk("rnd_pend", 64'(mb_pending), 64'(model_pvec()));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
